// File: rtl/align_fifo_nch.sv
`default_nettype none
// ============================================================================
// Module      : align_fifo_nch
// Description : Per-lane alignment FIFOs re-emitted as one row-major stream.
// Revision    : 1.0 - initial release
// ============================================================================
module align_fifo_nch #(
    parameter int LANES = 8,
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int CW    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CW-1:0]       cfg_m,
    input  logic [CW-1:0]       cfg_p,
    input  logic [LANES-1:0]    in_valid,
    input  logic [LANES*DW-1:0] in_data,
    output logic [LANES-1:0]    in_ready,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic                err_cfg
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = AW + 1;
    localparam int TW = 2 * CW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]    state_q,    state_d;
    logic [CW-1:0] m_q,        m_d;
    logic [CW-1:0] p_q,        p_d;
    logic [LW-1:0] lane_ptr_q, lane_ptr_d;
    logic [CW-1:0] row_ptr_q,  row_ptr_d;
    logic [TW-1:0] emitted_q,  emitted_d;
    logic          ov_q,       ov_d;
    logic [DW-1:0] od_q,       od_d;
    logic          done_q,     done_d;
    logic          err_q,      err_d;

    logic [LANES-1:0] w_empty;
    logic [LANES-1:0] w_full;
    logic [DW-1:0]    w_head [LANES];

    logic          w_run;
    logic          w_cfg_ok;
    logic          w_start_ok;
    logic [TW-1:0] w_total;
    logic          w_hs;
    logic          w_load;
    logic          w_lane_last;
    logic          w_last;

    assign w_run      = (state_q == S_RUN);
    assign w_cfg_ok   = (cfg_m != '0) && (32'(cfg_m) <= DEPTH) &&
                        (cfg_p != '0) && (32'(cfg_p) <= LANES);
    assign w_start_ok = (state_q == S_IDLE) && start && w_cfg_ok;
    assign w_total    = TW'(m_q) * TW'(p_q);
    assign w_hs       = ov_q && out_ready;
    assign w_load     = w_run && (!ov_q || out_ready) && !w_empty[lane_ptr_q] &&
                        (emitted_q < w_total);
    assign w_lane_last = (CW'(lane_ptr_q) == (p_q - CW'(1)));
    // Last word of the tile: final lane of the final row.
    assign w_last     = w_lane_last && (row_ptr_q == (m_q - CW'(1)));

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DW-1:0] mem_q [DEPTH];
        logic [AW-1:0] wptr_q;
        logic [AW-1:0] rptr_q;
        logic [NW-1:0] cnt_q;
        logic [CW-1:0] wr_cnt_q;
        logic          w_wr;
        logic          w_rd;

        assign w_empty[gi]  = (cnt_q == '0);
        assign w_full[gi]   = (cnt_q == NW'(DEPTH));
        assign in_ready[gi] = w_run && (CW'(gi) < p_q) && (wr_cnt_q < m_q) && !w_full[gi];
        assign w_wr         = in_valid[gi] && in_ready[gi];
        assign w_rd         = w_load && (lane_ptr_q == LW'(gi));
        assign w_head[gi]   = mem_q[rptr_q];

        always_ff @(posedge clk) begin
            if (w_wr) begin
                mem_q[wptr_q] <= in_data[gi*DW +: DW];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr_q   <= '0;
                rptr_q   <= '0;
                cnt_q    <= '0;
                wr_cnt_q <= '0;
            end else begin
                if (w_start_ok) begin
                    wr_cnt_q <= '0;
                end else if (w_wr) begin
                    wr_cnt_q <= wr_cnt_q + CW'(1);
                end
                if (w_wr) begin
                    wptr_q <= wptr_q + AW'(1);
                end
                if (w_rd) begin
                    rptr_q <= rptr_q + AW'(1);
                end
                if (w_wr && !w_rd) begin
                    cnt_q <= cnt_q + NW'(1);
                end else if (!w_wr && w_rd) begin
                    cnt_q <= cnt_q - NW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        p_d        = p_q;
        lane_ptr_d = lane_ptr_q;
        row_ptr_d  = row_ptr_q;
        emitted_d  = emitted_q;
        ov_d       = ov_q;
        od_d       = od_q;
        done_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (w_cfg_ok) begin
                        state_d    = S_RUN;
                        m_d        = cfg_m;
                        p_d        = cfg_p;
                        lane_ptr_d = '0;
                        row_ptr_d  = '0;
                        emitted_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (w_load) begin
                    ov_d      = 1'b1;
                    od_d      = w_head[lane_ptr_q];
                    emitted_d = emitted_q + TW'(1);
                    if (w_lane_last) begin
                        lane_ptr_d = '0;
                        row_ptr_d  = row_ptr_q + CW'(1);
                    end else begin
                        lane_ptr_d = lane_ptr_q + LW'(1);
                    end
                    if (w_last) begin
                        state_d = S_FLUSH;
                    end
                end else if (w_hs) begin
                    ov_d = 1'b0;
                end
            end
            S_FLUSH: begin
                if (w_hs) begin
                    ov_d    = 1'b0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            p_q        <= '0;
            lane_ptr_q <= '0;
            row_ptr_q  <= '0;
            emitted_q  <= '0;
            ov_q       <= 1'b0;
            od_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            p_q        <= p_d;
            lane_ptr_q <= lane_ptr_d;
            row_ptr_q  <= row_ptr_d;
            emitted_q  <= emitted_d;
            ov_q       <= ov_d;
            od_q       <= od_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err_cfg   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_align_fifo_nch.sv
`default_nettype none
// ============================================================================
// Module      : tb_align_fifo_nch
// Description : Randomised self-checking bench for align_fifo_nch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_align_fifo_nch;

    localparam int LANES  = 8;
    localparam int DW     = 32;
    localparam int DEPTH  = 16;
    localparam int CW     = 8;
    localparam int BUDGET = 3000;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [CW-1:0]       cfg_m = '0;
    logic [CW-1:0]       cfg_p = '0;
    logic [LANES-1:0]    in_valid = '0;
    logic [LANES*DW-1:0] in_data = '0;
    logic [LANES-1:0]    in_ready;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic                out_ready = 1'b0;
    logic                busy;
    logic                done;
    logic                err_cfg;

    align_fifo_nch #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_m(cfg_m), .cfg_p(cfg_p),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .err_cfg(err_cfg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: each lane's accepted words by row; expected stream is
    // row-major over (row, lane) of what was actually accepted.
    logic [DW-1:0] sent [LANES][DEPTH];
    logic [DW-1:0] pend [LANES];
    int acc [LANES];
    int n_got, n_bad_data, viol_lane, viol_stall, cyc, timed_out;
    int first_acc0, first_ov, first_hs, last_hs, done_cyc, done_hi;
    logic busy_at_done, busy_at_last;

    task automatic run_tile(input int m, input int p, input int rdy_mode, input int vpct,
                            input int skew0, input int drive_all, input int stop_after);
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          v;
        int            k, ln, rw;
        for (int l = 0; l < LANES; l++) begin
            acc[l]  = 0;
            pend[l] = {8'(l), 8'(0), 16'($urandom)};
        end
        n_got = 0; n_bad_data = 0; viol_lane = 0; viol_stall = 0; timed_out = 0;
        first_acc0 = -1; first_ov = -1; first_hs = -1; last_hs = -1;
        done_cyc = -1; done_hi = 0; busy_at_done = 1'bx; busy_at_last = 1'bx;
        prev_stall = 1'b0; prev_data = '0;
        cfg_m = CW'(m); cfg_p = CW'(p); start = 1'b1;
        cyc = 0;
        forever begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) viol_stall++;
            if (out_valid === 1'b1 && first_ov < 0) first_ov = cyc;
            if (done === 1'b1) begin
                done_hi++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    busy_at_done = busy;
                end
            end
            for (int l = 0; l < LANES; l++) begin
                v = (l < (drive_all != 0 ? LANES : p)) && (acc[l] < m) &&
                    ($urandom_range(99) < vpct) && !(l == 0 && cyc <= skew0);
                in_valid[l] = v;
                in_data[l*DW +: DW] = pend[l];
            end
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 2) == 1);
                default: out_ready = ($urandom_range(1) == 1);
            endcase
            #1;
            for (int l = 0; l < LANES; l++) begin
                if (in_ready[l] === 1'b1) begin
                    if (l >= p || acc[l] >= m) viol_lane++;
                    if (in_valid[l]) begin
                        if (acc[l] < DEPTH) sent[l][acc[l]] = pend[l];
                        if (l == 0 && first_acc0 < 0) first_acc0 = cyc;
                        acc[l]++;
                        pend[l] = {8'(l), 8'(acc[l]), 16'($urandom)};
                    end
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                k = n_got;
                if (k < m * p) begin
                    ln = k % p;
                    rw = k / p;
                    if (rw >= acc[ln] || out_data !== sent[ln][rw]) n_bad_data++;
                end else begin
                    n_bad_data++;
                end
                n_got++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                busy_at_last = busy;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_data  = out_data;
            if (stop_after > 0 && n_got == stop_after) break;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            if (cyc >= BUDGET) begin
                timed_out = 1;
                break;
            end
        end
        in_valid  = '0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== '0) begin n_errors++; $display("FAIL reset_in_ready: got %h expected 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (err_cfg !== 1'b0) begin n_errors++; $display("FAIL reset_err_cfg: got %b expected 0", err_cfg); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_tile(4, 8, 0, 100, 0, 1, 0);
        n_checks++; if (timed_out !== 0) begin n_errors++; $display("FAIL basic_timeout: got %0d expected 0", timed_out); end
        n_checks++; if (n_got !== 32) begin n_errors++; $display("FAIL basic_count: got %0d expected 32", n_got); end
        n_checks++; if (n_bad_data !== 0) begin n_errors++; $display("FAIL basic_order: got %0d bad words expected 0", n_bad_data); end
        for (int l = 0; l < LANES; l++) begin
            n_checks++; if (acc[l] !== 4) begin n_errors++; $display("FAIL basic_accepts lane%0d: got %0d expected 4", l, acc[l]); end
        end
        n_checks++; if (first_ov !== first_acc0 + 2) begin n_errors++; $display("FAIL basic_latency: got cycle %0d expected %0d", first_ov, first_acc0 + 2); end
        n_checks++; if (last_hs - first_hs !== 31) begin n_errors++; $display("FAIL basic_throughput: got span %0d expected 31", last_hs - first_hs); end
        n_checks++; if (done_cyc !== last_hs + 1) begin n_errors++; $display("FAIL basic_done_timing: got %0d expected %0d", done_cyc, last_hs + 1); end
        n_checks++; if (done_hi !== 1) begin n_errors++; $display("FAIL basic_done_width: got %0d expected 1", done_hi); end
        n_checks++; if (busy_at_done !== 1'b0) begin n_errors++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_at_done); end
        n_checks++; if (busy_at_last !== 1'b1) begin n_errors++; $display("FAIL basic_busy_at_last: got %b expected 1", busy_at_last); end
        n_checks++; if (viol_lane !== 0) begin n_errors++; $display("FAIL basic_in_ready: got %0d violations expected 0", viol_lane); end
    endtask

    task automatic test_partial();
        run_tile(3, 2, 2, 70, 0, 1, 0);
        n_checks++; if (timed_out !== 0) begin n_errors++; $display("FAIL partial_timeout: got %0d expected 0", timed_out); end
        n_checks++; if (n_got !== 6) begin n_errors++; $display("FAIL partial_count: got %0d expected 6", n_got); end
        n_checks++; if (n_bad_data !== 0) begin n_errors++; $display("FAIL partial_order: got %0d bad words expected 0", n_bad_data); end
        n_checks++; if (acc[0] !== 3 || acc[1] !== 3) begin n_errors++; $display("FAIL partial_accepts: got %0d/%0d expected 3/3", acc[0], acc[1]); end
        n_checks++; if (viol_lane !== 0) begin n_errors++; $display("FAIL partial_in_ready: got %0d violations expected 0", viol_lane); end
        n_checks++; if (viol_stall !== 0) begin n_errors++; $display("FAIL partial_stall: got %0d violations expected 0", viol_stall); end
        n_checks++; if (done_hi !== 1) begin n_errors++; $display("FAIL partial_done_width: got %0d expected 1", done_hi); end
    endtask

    task automatic test_skew();
        int short_lanes;
        run_tile(16, 8, 0, 100, 10, 1, 0);
        short_lanes = 0;
        for (int l = 0; l < LANES; l++) if (acc[l] != 16) short_lanes++;
        n_checks++; if (timed_out !== 0) begin n_errors++; $display("FAIL skew_timeout: got %0d expected 0", timed_out); end
        n_checks++; if (n_got !== 128) begin n_errors++; $display("FAIL skew_count: got %0d expected 128", n_got); end
        n_checks++; if (n_bad_data !== 0) begin n_errors++; $display("FAIL skew_order: got %0d bad words expected 0", n_bad_data); end
        n_checks++; if (short_lanes !== 0) begin n_errors++; $display("FAIL skew_accepts: got %0d short lanes expected 0", short_lanes); end
        n_checks++; if (first_ov !== first_acc0 + 2) begin n_errors++; $display("FAIL skew_first_out: got cycle %0d expected %0d", first_ov, first_acc0 + 2); end
        n_checks++; if (viol_lane !== 0) begin n_errors++; $display("FAIL skew_in_ready: got %0d violations expected 0", viol_lane); end
    endtask

    task automatic test_backpressure();
        run_tile(4, 4, 1, 100, 0, 1, 0);
        n_checks++; if (n_got !== 16) begin n_errors++; $display("FAIL bp_count: got %0d expected 16", n_got); end
        n_checks++; if (n_bad_data !== 0) begin n_errors++; $display("FAIL bp_order: got %0d bad words expected 0", n_bad_data); end
        n_checks++; if (viol_stall !== 0) begin n_errors++; $display("FAIL bp_stall_stable: got %0d violations expected 0", viol_stall); end
        n_checks++; if (done_cyc !== last_hs + 1) begin n_errors++; $display("FAIL bp_done_timing: got %0d expected %0d", done_cyc, last_hs + 1); end
        n_checks++; if (done_hi !== 1) begin n_errors++; $display("FAIL bp_done_width: got %0d expected 1", done_hi); end
    endtask

    task automatic test_illegal_cfg();
        int bad_ready;
        bad_ready = 0;
        in_valid = '1;
        cfg_m = CW'(4); cfg_p = CW'(0); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (err_cfg !== 1'b1) begin n_errors++; $display("FAIL illegal_p0_err: got %b expected 1", err_cfg); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL illegal_p0_busy: got %b expected 0", busy); end
        cfg_m = CW'(17); cfg_p = CW'(4); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (in_ready !== '0 || busy !== 1'b0) bad_ready++;
            @(posedge clk); #1;
        end
        n_checks++; if (bad_ready !== 0) begin n_errors++; $display("FAIL illegal_m17_idle: got %0d active cycles expected 0", bad_ready); end
        n_checks++; if (err_cfg !== 1'b1) begin n_errors++; $display("FAIL illegal_m17_err: got %b expected 1", err_cfg); end
        in_valid = '0;
        run_tile(2, 3, 2, 80, 0, 0, 0);
        n_checks++; if (n_got !== 6) begin n_errors++; $display("FAIL illegal_then_legal_count: got %0d expected 6", n_got); end
        n_checks++; if (n_bad_data !== 0) begin n_errors++; $display("FAIL illegal_then_legal_order: got %0d bad words expected 0", n_bad_data); end
        n_checks++; if (err_cfg !== 1'b1) begin n_errors++; $display("FAIL illegal_sticky: got %b expected 1", err_cfg); end
    endtask

    task automatic test_reset_mid_tile();
        run_tile(4, 8, 0, 100, 0, 1, 10);
        n_checks++; if (n_got !== 10) begin n_errors++; $display("FAIL midrst_prefix: got %0d expected 10", n_got); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_errors++; $display("FAIL midrst_out_data: got %h expected 0", out_data); end
        n_checks++; if (in_ready !== '0) begin n_errors++; $display("FAIL midrst_in_ready: got %h expected 0", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (err_cfg !== 1'b0) begin n_errors++; $display("FAIL midrst_err_cfg: got %b expected 0", err_cfg); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_tile(2, 2, 0, 100, 0, 1, 0);
        n_checks++; if (n_got !== 4) begin n_errors++; $display("FAIL midrst_new_count: got %0d expected 4", n_got); end
        n_checks++; if (n_bad_data !== 0) begin n_errors++; $display("FAIL midrst_new_order: got %0d bad words expected 0", n_bad_data); end
        n_checks++; if (done_hi !== 1) begin n_errors++; $display("FAIL midrst_new_done: got %0d expected 1", done_hi); end
    endtask

    task automatic test_random();
        int m, p, rm, vp;
        for (int it = 0; it < 6; it++) begin
            m  = $urandom_range(DEPTH, 1);
            p  = $urandom_range(LANES, 1);
            rm = $urandom_range(2);
            vp = $urandom_range(100, 30);
            run_tile(m, p, rm, vp, 0, $urandom_range(1), 0);
            n_checks++; if (n_got !== m * p) begin n_errors++; $display("FAIL rand%0d_count m=%0d p=%0d: got %0d expected %0d", it, m, p, n_got, m * p); end
            n_checks++; if (n_bad_data !== 0) begin n_errors++; $display("FAIL rand%0d_order: got %0d bad words expected 0", it, n_bad_data); end
            n_checks++; if (done_cyc !== last_hs + 1) begin n_errors++; $display("FAIL rand%0d_done_timing: got %0d expected %0d", it, done_cyc, last_hs + 1); end
            n_checks++; if (viol_stall !== 0 || viol_lane !== 0) begin n_errors++; $display("FAIL rand%0d_protocol: got %0d/%0d violations expected 0/0", it, viol_stall, viol_lane); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_skew();
        test_backpressure();
        test_illegal_cfg();
        test_reset_mid_tile();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
